// File: rtl/sram_arbiter_pkg.sv
// Shared bus macros, FSM encodings, width codes and the alignment rule for sram_arbiter.
// Optional feature macro used by this slice: SRAM_ARB_RR_EN (round-robin arbitration).
`ifndef SRAM_ARBITER_DEFS
`define SRAM_ARBITER_DEFS
`define ADDR_BUS  31:0
`define DATA_BUS  31:0
`define ZERO_WORD 32'h0000_0000
`define FALSE     1'b0
`define TRUE      1'b1
`endif

package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_e;

    localparam logic [3:0] WIDTH_BYTE = 4'h1;
    localparam logic [3:0] WIDTH_HALF = 4'h2;
    localparam logic [3:0] WIDTH_WORD = 4'h4;

    // Only naturally aligned byte/half/word accesses reach the bridge.
    function automatic logic access_ok(input logic [3:0] width, input logic [1:0] addr_lo);
        case (width)
            WIDTH_BYTE: access_ok = 1'b1;
            WIDTH_HALF: access_ok = (addr_lo[0] == 1'b0);
            WIDTH_WORD: access_ok = (addr_lo == 2'b00);
            default:    access_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sram_arbiter_pick.sv
// Combinational winner selection between the two requesters.
// SRAM_ARB_RR_EN selects round-robin tie breaking; otherwise port 0 has fixed priority.
module sram_arb_pick
    import sram_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic grant_valid,
    output logic grant_id
);

`ifdef SRAM_ARB_RR_EN
    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant_id = ptr;
        end else begin
            grant_id = req1;
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ptr;

    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = ~req0;
    end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and access sequencer in front of the load/store SRAM bridge.
// Define SRAM_ARB_RR_EN for round-robin arbitration (default: port 0 fixed priority).
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [`ADDR_BUS] addr0,
    input  logic [`ADDR_BUS] addr1,
    input  logic [3:0]       width0,
    input  logic [3:0]       width1,
    input  logic [`DATA_BUS] wdata0,
    input  logic [`DATA_BUS] wdata1,
    output logic             ack0,
    output logic             ack1,
    output logic             err0,
    output logic             err1,
    output logic [`DATA_BUS] rdata,
    output logic             mem_ce,
    output logic             mem_we,
    output logic [`ADDR_BUS] mem_addr,
    output logic [3:0]       mem_width,
    output logic [`DATA_BUS] mem_wdata,
    input  logic [`DATA_BUS] mem_rdata
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    arb_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             id_q, id_d;
    logic             ack0_q, ack0_d, ack1_q, ack1_d;
    logic             err0_q, err0_d, err1_q, err1_d;
    logic [`DATA_BUS] rdata_q, rdata_d;
    logic             mem_ce_q, mem_ce_d, mem_we_q, mem_we_d;
    logic [`ADDR_BUS] mem_addr_q, mem_addr_d;
    logic [3:0]       mem_width_q, mem_width_d;
    logic [`DATA_BUS] mem_wdata_q, mem_wdata_d;

    logic             ptr_sel;
    logic             grant_valid, grant_id;
    logic             sel_we;
    logic [`ADDR_BUS] sel_addr;
    logic [3:0]       sel_width;
    logic [`DATA_BUS] sel_wdata;

`ifdef SRAM_ARB_RR_EN
    logic ptr_q, ptr_d;
    assign ptr_sel = ptr_q;
`else
    assign ptr_sel = 1'b0;
`endif

    sram_arb_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .ptr         (ptr_sel),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign sel_we    = grant_id ? we1    : we0;
    assign sel_addr  = grant_id ? addr1  : addr0;
    assign sel_width = grant_id ? width1 : width0;
    assign sel_wdata = grant_id ? wdata1 : wdata0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        ack0_d      = `FALSE;
        ack1_d      = `FALSE;
        err0_d      = `FALSE;
        err1_d      = `FALSE;
        rdata_d     = rdata_q;
        mem_ce_d    = `FALSE;
        mem_we_d    = `FALSE;
        mem_wdata_d = `ZERO_WORD;
        mem_addr_d  = mem_addr_q;
        mem_width_d = mem_width_q;
`ifdef SRAM_ARB_RR_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (grant_valid) begin
                    id_d        = grant_id;
                    cnt_d       = CNT_LOAD;
                    mem_addr_d  = sel_addr;
                    mem_width_d = sel_width;
`ifdef SRAM_ARB_RR_EN
                    ptr_d       = ~grant_id;
`endif
                    if (access_ok(sel_width, sel_addr[1:0])) begin
                        state_d     = ARB_ACCESS;
                        mem_ce_d    = `TRUE;
                        mem_we_d    = sel_we;
                        mem_wdata_d = sel_wdata;
                    end else begin
                        // Rejected requests report straight away without touching the bridge.
                        state_d = ARB_DONE;
                        rdata_d = `ZERO_WORD;
                        ack0_d  = ~grant_id;
                        ack1_d  = grant_id;
                        err0_d  = ~grant_id;
                        err1_d  = grant_id;
                    end
                end
            end
            ARB_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ARB_DONE;
                    rdata_d = mem_we_q ? `ZERO_WORD : mem_rdata;
                    ack0_d  = ~id_q;
                    ack1_d  = id_q;
                end else begin
                    cnt_d       = cnt_q - 4'd1;
                    mem_ce_d    = `TRUE;
                    mem_we_d    = mem_we_q;
                    mem_wdata_d = mem_wdata_q;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            cnt_q       <= 4'd0;
            id_q        <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            rdata_q     <= `ZERO_WORD;
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_width_q <= 4'd0;
            mem_wdata_q <= `ZERO_WORD;
`ifdef SRAM_ARB_RR_EN
            ptr_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
            rdata_q     <= rdata_d;
            mem_ce_q    <= mem_ce_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_width_q <= mem_width_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef SRAM_ARB_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign rdata     = rdata_q;
    assign mem_ce    = mem_ce_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_width = mem_width_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed plan items plus randomized single/tied requests.
// Honours SRAM_ARB_RR_EN in its arbitration model.
module tb_sram_arbiter;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic [3:0]  width0 = 0, width1 = 0;
    logic        ack0, ack1, err0, err1, mem_ce, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_width;

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  width;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   model_ptr = 0;
    int   ce_cnt = 0;
    bit   prev_ce = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .width0(width0), .width1(width1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_width(mem_width),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Bridge model: a fixed pseudo-random memory image, already lane-extracted.
    function automatic logic [31:0] mem_model(input logic [31:0] a, input logic [3:0] w);
        logic [31:0] word;
        word = (a == 32'h10) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h5A5A0000);
        if (w == 4'd1) return word & 32'h0000_00FF;
        if (w == 4'd2) return word & 32'h0000_FFFF;
        return word;
    endfunction

    assign mem_rdata = mem_model(mem_addr, mem_width);

    function automatic bit legal(input logic [31:0] a, input logic [3:0] w);
        return (w == 4'd1) || (w == 4'd2 && a % 2 == 0) || (w == 4'd4 && a % 4 == 0);
    endfunction

    function automatic exp_t make_exp(input bit port, input bit we, input logic [31:0] a,
                                      input logic [3:0] w, input logic [31:0] d);
        exp_t e;
        e.port = port; e.we = we; e.addr = a; e.width = w; e.wdata = d;
        e.err = !legal(a, w);
        e.rdata = (e.err || we) ? 32'h0 : mem_model(a, w);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: checks bridge activity against the head of the queue and pops on each ack.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            ce_cnt = 0;
            prev_ce = 0;
        end else begin
            chk("err0_needs_ack", {31'd0, err0 & ~ack0}, 32'd0);
            chk("err1_needs_ack", {31'd0, err1 & ~ack1}, 32'd0);
            if (mem_ce) begin
                chk("ce_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    chk("mem_we", {31'd0, mem_we}, {31'd0, exp_q[0].we});
                    chk("mem_addr", mem_addr, exp_q[0].addr);
                    chk("mem_width", {28'd0, mem_width}, {28'd0, exp_q[0].width});
                    chk("mem_wdata", mem_wdata, exp_q[0].wdata);
                end
                ce_cnt++;
            end else begin
                chk("idle_mem_we", {31'd0, mem_we}, 32'd0);
                chk("idle_mem_wdata", mem_wdata, 32'd0);
            end
            if (ack0 || ack1) begin
                chk("dual_ack", {31'd0, ack0 & ack1}, 32'd0);
                chk("ack_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("ack_port", {31'd0, ack1}, {31'd0, e.port});
                    chk("err", {31'd0, ack1 ? err1 : err0}, {31'd0, e.err});
                    if (!e.err) chk("rdata", rdata, e.rdata);
                    chk("ce_cycles", ce_cnt, e.err ? 0 : W);
                    chk("ack_follows_ce", {31'd0, prev_ce}, {31'd0, !e.err});
                end
                ce_cnt = 0;
            end
            prev_ce = mem_ce;
        end
    end

    task automatic model_grant(input bit port);
        exp_t e;
        e = make_exp(port, port ? we1 : we0, port ? addr1 : addr0,
                     port ? width1 : width0, port ? wdata1 : wdata0);
        exp_q.push_back(e);
        model_ptr = ~port;
    endtask

    task automatic run_txn(input bit r0, input bit r1,
                           input bit w_e0, input logic [31:0] a0, input logic [3:0] s0, input logic [31:0] d0,
                           input bit w_e1, input logic [31:0] a1, input logic [3:0] s1, input logic [31:0] d1);
        bit first;
        int cyc, lat;
        @(posedge clk); #1;
        we0 = w_e0; addr0 = a0; width0 = s0; wdata0 = d0;
        we1 = w_e1; addr1 = a1; width1 = s1; wdata1 = d1;
        if (r0 && r1) begin
`ifdef SRAM_ARB_RR_EN
            first = model_ptr;
`else
            first = 1'b0;
`endif
            model_grant(first);
            model_grant(~first);
        end else if (r0) model_grant(1'b0);
        else if (r1) model_grant(1'b1);
        req0 = r0; req1 = r1;
        cyc = 0; lat = -1;
        while ((req0 || req1) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (ack0) begin req0 = 0; lat = cyc; end
            if (ack1) begin req1 = 0; lat = cyc; end
        end
        chk("txn_timeout", {31'd0, req0 | req1}, 32'd0);
        req0 = 0; req1 = 0;
        if (r0 ^ r1) chk("ack_latency", lat, legal(r0 ? a0 : a1, r0 ? s0 : s1) ? W + 1 : 1);
    endtask

    task automatic rand_fields(output bit we, output logic [31:0] a, output logic [3:0] w,
                               output logic [31:0] d);
        logic [3:0] wtab [9];
        wtab = '{4'd1, 4'd2, 4'd4, 4'd4, 4'd2, 4'd1, 4'd3, 4'd0, 4'd8};
        w  = wtab[$urandom_range(0, 8)];
        a  = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0 && (w == 4'd2 || w == 4'd4)) a = a & ~(32'(w) - 32'd1);
        we = 1'($urandom_range(0, 1));
        d  = $urandom;
    endtask

    initial begin
        #100_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        bit we_a, we_b;
        logic [31:0] a_a, a_b, d_a, d_b;
        logic [3:0] s_a, s_b;
        int sel;

        #12;
        chk("rst_ack0", {31'd0, ack0}, 32'd0);
        chk("rst_ack1", {31'd0, ack1}, 32'd0);
        chk("rst_err", {30'd0, err0, err1}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_ce", {31'd0, mem_ce}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_width", {28'd0, mem_width}, 32'd0);
        @(posedge clk); #1 rst_n = 1;

        run_txn(1, 0, 0, 32'h10, 4'd4, 32'h0, 0, 32'h0, 4'd1, 32'h0);
        run_txn(0, 1, 0, 32'h0, 4'd1, 32'h0, 1, 32'h23, 4'd1, 32'h5A);
        run_txn(1, 1, 0, 32'h20, 4'd4, 32'h0, 0, 32'h31, 4'd1, 32'h0);
        run_txn(1, 1, 0, 32'h22, 4'd2, 32'h0, 0, 32'h44, 4'd4, 32'h0);
        run_txn(1, 0, 0, 32'h11, 4'd2, 32'h0, 0, 32'h0, 4'd1, 32'h0);
        run_txn(0, 1, 0, 32'h0, 4'd1, 32'h0, 0, 32'h08, 4'd3, 32'h0);
        run_txn(1, 0, 0, 32'h0C, 4'd4, 32'h0, 0, 32'h0, 4'd1, 32'h0);

        // Reset during the second ACCESS cycle abandons the access.
        @(posedge clk); #1;
        we0 = 0; addr0 = 32'h40; width0 = 4'd4; wdata0 = 32'h0;
        model_grant(1'b0);
        req0 = 1;
        @(posedge clk); #1;
        chk("rst_test_ce_first", {31'd0, mem_ce}, 32'd1);
        @(posedge clk); #2;
        rst_n = 0; #1;
        chk("rst_async_ce", {31'd0, mem_ce}, 32'd0);
        chk("rst_async_ack", {31'd0, ack0}, 32'd0);
        req0 = 0;
        exp_q.delete();
        model_ptr = 0;
        @(posedge clk); @(posedge clk); #1 rst_n = 1;
        run_txn(1, 0, 0, 32'h40, 4'd4, 32'h0, 0, 32'h0, 4'd1, 32'h0);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 2);
            rand_fields(we_a, a_a, s_a, d_a);
            rand_fields(we_b, a_b, s_b, d_b);
            run_txn(sel != 1, sel != 0, we_a, a_a, s_a, d_a, we_b, a_b, s_b, d_b);
        end

        repeat (4) @(posedge clk);
        #1 chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
